uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Transmit-side controller that drains the 8-entry, 8-bit TX byte FIFO into the UART transmitter, one frame at a time. It issues single-cycle FIFO read strobes and captures the registered FIFO output. It launches the transmitter with a start pulse and tracks the transmitter's busy handshake. It also enforces a programmable inter-frame gap and detects a transmitter that never acknowledges. Sits between the host-write FIFO and the bit-serialiser in the UART core.

## Interface
- GAP_CYCLES, 0, idle clocks inserted after each frame's busy falls (0 = no gap)
- ACK_TIMEOUT, 4, clocks allowed after tx_start for tx_busy to rise (1..15)
- clock  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  permits new frames to launch; a frame already launched always completes
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  8  FIFO registered read data; valid the cycle after an accepted read strobe
- fifo_rd_en  output  1  FIFO read strobe; high exactly one cycle per byte
- tx_busy  input  1  transmitter busy; high while a frame is on the line
- tx_start  output  1  one-cycle launch pulse to the transmitter
- tx_data  output  8  byte to transmit; stable from START until the next LOAD
- active  output  1  high in every state except IDLE
- frames_sent  output  16  count of frames whose tx_busy fell; wraps 0xFFFF->0x0000
- err_timeout  output  1  sticky; set when tx_busy fails to rise within ACK_TIMEOUT

## Operation
- States: IDLE, FETCH, LOAD, START, ACK, BUSY, GAP.
- IDLE -> FETCH when enable=1, fifo_empty=0, and the flow-control condition holds (see Configuration).
- FETCH: fifo_rd_en=1. Always -> LOAD.
- LOAD: tx_data <= fifo_data at the closing edge. -> START.
- START: tx_start=1. Timeout counter cleared. -> ACK.
- ACK: if tx_busy=1 -> BUSY. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT: set err_timeout, go to GAP, frame not counted.
- BUSY: wait for tx_busy=0. On the falling detection, frames_sent += 1 and go to GAP. If GAP_CYCLES=0, go to IDLE instead.
- GAP: count GAP_CYCLES clocks, then -> IDLE. A timeout entry into GAP with GAP_CYCLES=0 still spends 1 cycle in GAP.
- fifo_rd_en, tx_start, and active are decoded from the registered state only. They have no combinational path from inputs.
- enable deasserted mid-frame: the current byte completes through GAP, and no new FETCH follows. enable is sampled only in IDLE.
- fifo_empty is sampled only in IDLE. FETCH is issued only after non-empty was seen, so the strobe is never wasted.
- err_timeout clears only on reset. Scheduling continues after a timeout.
- Reset mid-frame: state returns to IDLE next cycle and the in-flight byte is abandoned. The transmitter is responsible for its own reset.
- Reset values: fifo_rd_en=0, tx_start=0, tx_data=0x00, active=0, frames_sent=0x0000, err_timeout=0, internal counters=0, flop-based synchroniser=0.

## Timing
- FIFO non-empty at IDLE cycle N: fifo_rd_en high in N+1, tx_data valid and tx_start high in N+3.
- Minimum launch-to-launch spacing is (frame busy length) + 1 ACK cycle + GAP_CYCLES + 4.
- tx_busy rising in the same cycle as tx_start is not seen. The earliest accepted rise is the first ACK cycle.
- Timeout: err_timeout is high ACK_TIMEOUT+1 cycles after the tx_start cycle.

## Configuration
- TXSCHED_CTS_EN defined:
  - Adds input cts_n (active-low clear-to-send, asynchronous) with a 2-flop synchroniser.
  - IDLE -> FETCH additionally requires the synchronised cts_n=0.
  - A cts_n change reaches the decision 2 cycles late.
  - cts_n deasserting mid-frame does not abort the frame.
- TXSCHED_CTS_EN undefined: no cts_n port, no synchroniser, and the flow-control condition is always true.

## Test plan
- Single byte: write 0x5A to the FIFO, enable=1, with a transmitter model that asserts busy 1 cycle after tx_start for 10 cycles, GAP_CYCLES=0. Required: one fifo_rd_en pulse, then tx_start with tx_data=0x5A 2 cycles after it, frames_sent=1, and the FIFO ends empty.
- Burst of 7 bytes 0x01..0x07, GAP_CYCLES=3. Required: 7 launches in order, at least 3 idle cycles between each busy fall and the next fifo_rd_en, and frames_sent=7.
- Transmitter never asserts busy, ACK_TIMEOUT=4. Required: err_timeout=1 at 5 cycles after tx_start, frames_sent unchanged, and the next queued byte is still launched.
- enable dropped during BUSY of byte 1 of 3. Required: byte 1 completes, no further fifo_rd_en, and 2 bytes remain. Re-enable and the remaining bytes resume in order.
- Reset asserted in ACK. Required: all outputs at reset values the next cycle, and frames_sent=0.
- TXSCHED_CTS_EN: cts_n=1 with a non-empty FIFO. Required: no fifo_rd_en. Drop cts_n to 0 and fifo_rd_en is seen 3 cycles later.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// FIFO-read and transmitter-launch signals between the TX scheduler and its neighbours.
interface uart_tx_scheduler_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  fifo_empty, fifo_data, tx_busy,
        output fifo_rd_en, tx_start, tx_data
    );

    modport slave (
        output fifo_empty, fifo_data, tx_busy,
        input  fifo_rd_en, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: drains the TX byte FIFO into the UART transmitter.
// Optional CTS flow control is built when TXSCHED_CTS_EN is defined.
module uart_tx_scheduler #(
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
`ifdef TXSCHED_CTS_EN
    input  logic                cts_n,
`endif
    uart_tx_scheduler_if.master bus,
    output logic                active,
    output logic [15:0]         frames_sent,
    output logic                err_timeout
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        ACK,
        BUSY,
        GAP
    } state_e;

    localparam logic [3:0]  ACK_LIM = 4'(ACK_TIMEOUT);
    localparam logic [15:0] GAP_LIM = 16'(GAP_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  ack_cnt_q, ack_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  tx_data_q;
    logic [15:0] frames_q;
    logic        rd_en_q, start_q, active_q, err_q;
    logic        frame_done, timeout, cts_ok;

`ifdef TXSCHED_CTS_EN
    logic cts_meta_q, cts_sync_q;
    assign cts_ok = ~cts_sync_q;
`else
    assign cts_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ack_cnt_d  = ack_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        frame_done = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !bus.fifo_empty && cts_ok)
                    state_d = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD:  state_d = START;
            START: begin
                ack_cnt_d = '0;
                state_d   = ACK;
            end
            ACK: begin
                if (bus.tx_busy) begin
                    state_d = BUSY;
                end else begin
                    ack_cnt_d = ack_cnt_q + 4'd1;
                    if (ack_cnt_q + 4'd1 == ACK_LIM) begin
                        timeout   = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            BUSY: begin
                if (!bus.tx_busy) begin
                    frame_done = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                // A timeout entry with no gap configured still spends one cycle here.
                gap_cnt_d = gap_cnt_q + 16'd1;
                if ((GAP_LIM == 16'd0) || (gap_cnt_q == GAP_LIM - 16'd1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ack_cnt_q <= '0;
            gap_cnt_q <= '0;
            tx_data_q <= '0;
            frames_q  <= '0;
            rd_en_q   <= 1'b0;
            start_q   <= 1'b0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef TXSCHED_CTS_EN
            cts_meta_q <= 1'b0;
            cts_sync_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rd_en_q   <= (state_d == FETCH);
            start_q   <= (state_d == START);
            active_q  <= (state_d != IDLE);
            if (state_q == LOAD)
                tx_data_q <= bus.fifo_data;
            if (frame_done)
                frames_q <= frames_q + 16'd1;
            if (timeout)
                err_q <= 1'b1;
`ifdef TXSCHED_CTS_EN
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.tx_start   = start_q;
    assign bus.tx_data    = tx_data_q;
    assign active         = active_q;
    assign frames_sent    = frames_q;
    assign err_timeout    = err_q;
endmodule
